// File: rtl/cache_dm_pkg.sv
// Shared types and helpers for the direct-mapped cache controller.
package cache_dm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        RESP
    } cache_state_e;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LINES_DEF  = 8;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] idx;
    } addr_split_t;

    // Low idx_w bits select the line, the remaining upper bits form the tag.
    function automatic addr_split_t addr_split(input logic [31:0] addr,
                                               input int unsigned idx_w);
        addr_split_t s;
        s.idx = addr & ((32'd1 << idx_w) - 32'd1);
        s.tag = addr >> idx_w;
        return s;
    endfunction

endpackage

// File: rtl/cache_dm_array.sv
// Valid/tag/data storage: one combinational read port, one write port, bulk valid clear.
module cache_dm_array #(
    parameter int unsigned LINES  = 8,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned TAG_W  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Clear wins over a same-cycle fill so a reset or flush never leaves a stale line.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller with a refill FSM.
// Optional CACHE_DM_FLUSH_EN adds a flush input that clears all valid bits from IDLE.
module cache_dm_ctrl
    import cache_dm_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LINES  = LINES_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CACHE_DM_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    cache_state_e      state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;

    addr_split_t       split;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              unused_split;

    logic              arr_valid;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_clr;
    logic              flush_fire;
    logic              hit;

    assign split        = addr_split(32'(addr_q), IDX_W);
    assign idx          = split.idx[IDX_W-1:0];
    assign tag          = split.tag[TAG_W-1:0];
    assign unused_split = ^{split.tag[31:TAG_W], split.idx[31:IDX_W]};

    assign hit     = arr_valid && (arr_tag == tag);
    assign arr_clr = rst || flush_fire;

    cache_dm_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i      (clk),
        .clr_i      (arr_clr),
        .rd_idx_i   (idx),
        .rd_valid_o (arr_valid),
        .rd_tag_o   (arr_tag),
        .rd_data_o  (arr_data),
        .wr_en_i    (arr_we),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_wdata)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        arr_we     = 1'b0;
        arr_wdata  = wdata_q;
        flush_fire = 1'b0;
        req_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
`ifdef CACHE_DM_FLUSH_EN
                if (flush) begin
                    flush_fire = 1'b1;
                    req_ready  = 1'b0;
                end else
`endif
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = hit;
                if (we_q) begin
                    arr_we  = hit;
                    state_d = MEM_WR;
                end else if (hit) begin
                    rdata_d = arr_data;
                    state_d = RESP;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem_rdata;
                    rdata_d   = mem_rdata;
                    state_d   = RESP;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_hit   = hit_q && (state_q == RESP);
    assign mem_rd_en  = (state_q == MEM_RD);
    assign mem_wr_en  = (state_q == MEM_WR);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_cache_dm_ctrl.sv
// Directed bench for cache_dm_ctrl; covers the flush input when CACHE_DM_FLUSH_EN is defined.
module tb_cache_dm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
`ifdef CACHE_DM_FLUSH_EN
    logic       flush;
`endif
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_hit;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    cache_dm_ctrl #(
        .ADDR_W (5),
        .DATA_W (8),
        .LINES  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CACHE_DM_FLUSH_EN
        .flush      (flush),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_hit   (resp_hit),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; with use_mem the memory holds its ack off for 3 enabled cycles.
    task automatic xact(input string tag, input logic we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic use_mem, input logic [7:0] md,
                        input logic [7:0] exp_rd, input logic exp_hit);
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 5'h1F;
        req_wdata = 8'hEE;
        chk({tag, ".lk_ready"}, req_ready, 0);
        chk({tag, ".lk_resp"}, resp_valid, 0);
        chk({tag, ".lk_rd_en"}, mem_rd_en, 0);
        if (use_mem) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk({tag, ".rd_en"}, mem_rd_en, !we);
                chk({tag, ".wr_en"}, mem_wr_en, we);
                chk({tag, ".maddr"}, mem_addr, addr);
                if (we) chk({tag, ".mwdata"}, mem_wdata, wd);
                chk({tag, ".early_resp"}, resp_valid, 0);
            end
            mem_ack   = 1'b1;
            mem_rdata = md;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
        end else begin
            @(negedge clk);
        end
        chk({tag, ".resp"}, resp_valid, 1);
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".hit"}, resp_hit, exp_hit);
        chk({tag, ".rd_en_off"}, mem_rd_en, 0);
        chk({tag, ".wr_en_off"}, mem_wr_en, 0);
        @(negedge clk);
        chk({tag, ".resp_pulse"}, resp_valid, 0);
        chk({tag, ".ready_back"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
`ifdef CACHE_DM_FLUSH_EN
        flush     = 1'b0;
`endif
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst.ready", req_ready, 1);
        chk("rst.resp", resp_valid, 0);
        chk("rst.rdata", resp_rdata, 0);
        chk("rst.hit", resp_hit, 0);
        chk("rst.rd_en", mem_rd_en, 0);
        chk("rst.wr_en", mem_wr_en, 0);
        chk("rst.maddr", mem_addr, 0);
        chk("rst.mwdata", mem_wdata, 0);

        // Stray ack in IDLE must not start anything.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack.ready", req_ready, 1);
        chk("stray_ack.resp", resp_valid, 0);

        xact("t1_rd05_miss", 1'b0, 5'h05, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0);
        xact("t2_rd05_hit",  1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1);
        xact("t3_rd0D_miss", 1'b0, 5'h0D, 8'h00, 1'b1, 8'h5A, 8'h5A, 1'b0);
        xact("t3_rd05_evict", 1'b0, 5'h05, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0);
        xact("t4_rd0D_refill", 1'b0, 5'h0D, 8'h00, 1'b1, 8'h5A, 8'h5A, 1'b0);
        xact("t4_wr0D_hit",  1'b1, 5'h0D, 8'h3C, 1'b1, 8'h00, 8'h00, 1'b1);
        xact("t4_rd0D_hit",  1'b0, 5'h0D, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1);
        xact("t5_wr12_miss", 1'b1, 5'h12, 8'h77, 1'b1, 8'h00, 8'h00, 1'b0);
        xact("t5_rd12_miss", 1'b0, 5'h12, 8'h00, 1'b1, 8'h77, 8'h77, 1'b0);

        repeat (2) @(negedge clk);
        chk("hold.rdata", resp_rdata, 8'h77);
        chk("hold.resp", resp_valid, 0);

        // Reset while the read of 0x05 is waiting on memory.
        req_valid = 1'b1;
        req_addr  = 5'h05;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6.rd_en", mem_rd_en, 1);
        chk("t6.maddr", mem_addr, 5'h05);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6.rd_en_drop", mem_rd_en, 0);
        chk("t6.resp", resp_valid, 0);
        chk("t6.ready", req_ready, 1);
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        chk("t6.late_ack_resp", resp_valid, 0);
        chk("t6.late_ack_ready", req_ready, 1);
        xact("t6_rd0D_miss", 1'b0, 5'h0D, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0);
        xact("t6_rd05_miss", 1'b0, 5'h05, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0);

`ifdef CACHE_DM_FLUSH_EN
        xact("fl_rd05_hit", 1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 5'h05;
        chk("fl.ready_low", req_ready, 0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("fl.not_accepted", req_ready, 1);
        chk("fl.rd_en", mem_rd_en, 0);
        chk("fl.resp", resp_valid, 0);
        xact("fl_rd05_miss", 1'b0, 5'h05, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_dm_ctrl.md
Name: cache_dm_ctrl

Overview:
Parametrised direct-mapped cache controller; successor to the fixed 5-bit/8-bit cache memory.
- Sits between a tb/CPU-side request port and a slower backing memory with ack handshake.
- One word per line; read-allocate, write-through, no-write-allocate.
- Adds tag/valid tracking, hit/miss reporting and a multi-cycle refill FSM.

Parameters:
- ADDR_W, 5, request/memory address width in bits
- DATA_W, 8, data word width in bits
- LINES, 8, number of cache lines; power of 2, 2 to 2**(ADDR_W-1); IDX_W = $clog2(LINES), TAG_W = ADDR_W - IDX_W

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  read data; 0 for writes
- resp_hit  out  1  lookup hit, qualified by resp_valid
- mem_rd_en  out  1  backing read request, held until mem_ack
- mem_wr_en  out  1  backing write request, held until mem_ack
- mem_addr  out  ADDR_W  backing address
- mem_wdata  out  DATA_W  backing write data
- mem_rdata  in  DATA_W  backing read data, valid with mem_ack
- mem_ack  in  1  backing transfer complete; single-cycle pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - all outputs 0 except req_ready = 1; state IDLE; all valid bits 0.
  - Data/tag arrays are not reset.
- Address split: index = req_addr[IDX_W-1:0], tag = req_addr[ADDR_W-1:IDX_W].
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture we/addr/wdata, go to LOOKUP.
  - req_ready is 0 in every other state.
- LOOKUP: hit = valid[idx] && tag_arr[idx] == tag.
  - Read hit -> RESP with rdata = data_arr[idx].
  - Read miss -> MEM_RD.
  - Write -> MEM_WR. On hit, data_arr[idx] is updated this cycle; on miss, no allocate.
  - The hit flag is registered for resp_hit.
- MEM_RD:
  - mem_rd_en = 1, mem_addr = captured address.
  - On mem_ack: fill data/tag, set valid[idx], latch mem_rdata, go to RESP.
- MEM_WR:
  - mem_wr_en = 1, mem_addr/mem_wdata = captured values.
  - On mem_ack -> RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Latency:
  - Read hit: resp_valid 2 cycles after the accept edge.
  - Miss or write: 1 cycle after the mem_ack edge.
- mem_rd_en and mem_wr_en are never both high. Both drop in the cycle after mem_ack.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- A same-index different-tag read miss evicts and overwrites the line. No dirty state exists.
- Reset mid-operation: state returns to IDLE; mem_* enables drop the next cycle; all valid bits are cleared; any pending response is discarded.
- resp_rdata holds its value between responses.

Optional Feature:
- Macro: CACHE_DM_FLUSH_EN.
- With the macro:
  - Adds input port flush (1 bit).
  - flush sampled high in IDLE clears all valid bits in one cycle.
  - req_ready is 0 in that cycle, and flush takes priority over req_valid.
  - flush outside IDLE is ignored.
- Without the macro: no flush port; valid bits are cleared only by rst.

Decomposition:
- Package cache_dm_pkg holds:
  - state enum typedef cache_state_e (IDLE, LOOKUP, MEM_RD, MEM_WR, RESP);
  - default parameter constants;
  - a function splitting an address into tag/index.
- Sub-module cache_dm_array: valid/tag/data storage.
  - One combinational read port.
  - One write port (fill or write-hit update).
  - Bulk valid clear (reset/flush).

Test Plan (defaults ADDR_W=5, DATA_W=8, LINES=8):
1. After reset, read 0x05; memory acks 3 cycles after mem_rd_en with 0xA5 -> mem_addr = 0x05, one resp_valid, rdata = 0xA5, hit = 0.
2. Read 0x05 again -> resp_valid 2 cycles after accept, rdata = 0xA5, hit = 1, mem_rd_en never asserted.
3. Read 0x0D (index 5, tag 1) -> miss and refill. Then read 0x05 -> miss again, with mem_rd_en at 0x05.
4. With 0x0D cached, write 0x0D = 0x3C -> mem_wr_en, addr 0x0D, wdata 0x3C, hit = 1. Read 0x0D -> hit, rdata = 0x3C, no memory read.
5. Write 0x12 = 0x77 with 0x12 uncached -> memory write, hit = 0. Read 0x12 -> miss (no allocate).
6. Assert rst during MEM_RD for 0x05 -> mem_rd_en low the next cycle, no resp_valid, req_ready = 1. A later read of 0x05 misses. With CACHE_DM_FLUSH_EN: flush in IDLE after a fill makes the next read miss.
